// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud-tick generator, receiver fetch FSM, byte FIFO and sticky flags.
// Define UART_RX_CTRL_IRQ_EN to build the registered interrupt output; otherwise irq is 0.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BAUD_W = 13
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic [BAUD_W-1:0] baud_val,
   output logic              baud_tick,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   input  logic              rx_perr,
   input  logic              rx_ferr,
   input  logic              rx_ovf,
   output logic              rx_read,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              perr_st,
   output logic              ferr_st,
   output logic              ovf_st,
   input  logic              clr_status,
   output logic              irq
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

   state_e            state_q;
   logic              rx_read_q;
   logic [BAUD_W-1:0] baud_cnt_q;
   logic              baud_ld_q;
   logic              baud_tick_q;
   logic [BAUD_W-1:0] baud_cur;
   logic [7:0]        mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              empty_q, full_q;
   logic              push, pop, drop;
   logic              perr_q, ferr_q, ovf_q;
   logic              perr_d, ferr_d, ovf_d;

   // Out of reset the counter behaves as if it holds baud_val, without an async load of an input.
   assign baud_cur = baud_ld_q ? baud_val : baud_cnt_q;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         baud_cnt_q  <= '0;
         baud_ld_q   <= 1'b1;
         baud_tick_q <= 1'b0;
      end else begin
         baud_ld_q <= 1'b0;
         if (baud_cur == '0) begin
            baud_cnt_q  <= baud_val;
            baud_tick_q <= 1'b1;
         end else begin
            baud_cnt_q  <= baud_cur - BAUD_W'(1);
            baud_tick_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q   <= StIdle;
         rx_read_q <= 1'b0;
      end else begin
         rx_read_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (rx_rdy) begin
                  state_q   <= StFetch;
                  rx_read_q <= 1'b1;
               end
            end
            StFetch: state_q <= StWait;
            StWait:  if (!rx_rdy) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // A pop in the fetch cycle frees the slot the fetched byte lands in.
   assign push = (state_q == StFetch) && (!full_q || rd_en);
   assign drop = (state_q == StFetch) && full_q && !rd_en;
   assign pop  = rd_en && !empty_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge PCLK) begin
      if (push) mem_q[wptr_q] <= rx_data;
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   // Set wins over a coincident clear.
   assign perr_d = (perr_q & ~clr_status) | rx_perr;
   assign ferr_d = (ferr_q & ~clr_status) | rx_ferr;
   assign ovf_d  = (ovf_q & ~clr_status) | rx_ovf | drop;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         perr_q <= perr_d;
         ferr_q <= ferr_d;
         ovf_q  <= ovf_d;
      end
   end

`ifdef UART_RX_CTRL_IRQ_EN
   logic irq_q;

   // Built from next-state values so irq lines up with the flags it summarises.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (count_d != '0) | perr_d | ferr_d | ovf_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign baud_tick  = baud_tick_q;
   assign rx_read    = rx_read_q;
   assign rd_data    = mem_q[rptr_q];
   assign fifo_empty = empty_q;
   assign fifo_full  = full_q;
   assign perr_st    = perr_q;
   assign ferr_st    = ferr_q;
   assign ovf_st     = ovf_q;

endmodule
